// File: rtl/bcd_updown_counter.sv
// Purpose : DIGITS-digit up/down counter, every digit modulo RADIX (default 2-digit BCD 00..99),
//           with enable, direction, clamped parallel load, terminal-count look-ahead and wrap pulse.
// Latency : COUNT/WRAP update one CLK edge after the qualifying inputs; TC is combinational.
// Backpressure: none; the counter accepts a step or load on every edge.
//
// Ports:
//   CLK, RST_N      rising-edge clock, synchronous active-low reset
//   EN, UP          count enable, direction (1 = increment)
//   LOAD, LOAD_VAL  parallel load strobe and per-digit load value (digit 0 in [3:0])
//   COUNT, units    registered count (digit 0 in [3:0]); units = COUNT[3:0]
//   TC              next edge wraps the whole counter (for cascading)
//   WRAP            registered one-cycle pulse after a wrapping edge
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic [3:0]            units,
  output logic                  TC,
  output logic                  WRAP
);

  localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);

  logic [DIGITS-1:0][3:0] cnt_q;
  logic [DIGITS-1:0][3:0] cnt_step;
  logic [DIGITS-1:0][3:0] load_clamped;
  logic                   ripple;
  logic                   all_max;
  logic                   all_zero;
  logic                   wrap_q;

  // Step value: the carry/borrow ripples from digit 0 upward in one cycle. If it
  // survives past the top digit, every digit wrapped and so did the counter.
  always_comb begin
    cnt_step = cnt_q;
    ripple   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (UP) begin
          if (cnt_q[i] == MAX_DIGIT) begin
            cnt_step[i] = 4'd0;
          end else begin
            cnt_step[i] = cnt_q[i] + 4'd1;
            ripple      = 1'b0;
          end
        end else begin
          if (cnt_q[i] == 4'd0) begin
            cnt_step[i] = MAX_DIGIT;
          end else begin
            cnt_step[i] = cnt_q[i] - 4'd1;
            ripple      = 1'b0;
          end
        end
      end
    end
  end

  // Out-of-range load nibbles saturate to the top digit value so digits never
  // leave 0..RADIX-1.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, LOAD_VAL[i*4 +: 4]} >= 5'(RADIX)) begin
        load_clamped[i] = MAX_DIGIT;
      end else begin
        load_clamped[i] = LOAD_VAL[i*4 +: 4];
      end
    end
  end

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q[i] != MAX_DIGIT) all_max  = 1'b0;
      if (cnt_q[i] != 4'd0)      all_zero = 1'b0;
    end
  end

  // RST_N gates TC so a counter held in reset never signals a cascade step.
  assign TC = RST_N & EN & ~LOAD & (UP ? all_max : all_zero);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (LOAD) begin
      cnt_q  <= load_clamped;
      wrap_q <= 1'b0;
    end else if (EN) begin
      cnt_q  <= cnt_step;
      wrap_q <= ripple;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign COUNT = cnt_q;
  assign units = cnt_q[0];
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default 2-digit BCD instance
  logic       rst_n = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic [3:0] units;
  logic       tc, wrap;

  // Single hex-digit instance (RADIX=16, DIGITS=1)
  logic       rst_n16 = 1'b0, en16 = 1'b0, up16 = 1'b1, load16 = 1'b0;
  logic [3:0] load_val16 = 4'h0;
  logic [3:0] count16;
  logic [3:0] units16;
  logic       tc16, wrap16;

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(load_val),
    .COUNT(count), .units(units), .TC(tc), .WRAP(wrap)
  );

  bcd_updown_counter #(.DIGITS(1), .RADIX(16)) dut16 (
    .CLK(clk), .RST_N(rst_n16), .EN(en16), .UP(up16), .LOAD(load16), .LOAD_VAL(load_val16),
    .COUNT(count16), .units(units16), .TC(tc16), .WRAP(wrap16)
  );

  typedef struct {
    bit         d16;
    int         id;
    bit         chk_tc;
    bit         tc;
    logic [7:0] cnt;
    bit         wrap;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   vec_id = 0;
  bit   stim_done = 1'b0;

  function automatic void check(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
  endfunction

  // Monitor: expected TC is checked mid-cycle against the inputs of that step,
  // then COUNT/units/WRAP just after the edge that consumes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q[0];
        if (e.chk_tc) check("tc", e.id, {7'd0, e.d16 ? tc16 : tc}, {7'd0, e.tc});
        @(posedge clk);
        #1;
        e = q.pop_front();
        if (e.d16) begin
          check("count16", e.id, {4'h0, count16}, e.cnt);
          check("units16", e.id, {4'h0, units16}, {4'h0, e.cnt[3:0]});
          check("wrap16",  e.id, {7'd0, wrap16},  {7'd0, e.wrap});
        end else begin
          check("count", e.id, count, e.cnt);
          check("units", e.id, {4'h0, units}, {4'h0, e.cnt[3:0]});
          check("wrap",  e.id, {7'd0, wrap},  {7'd0, e.wrap});
        end
      end
    end
  end

  // Driver: apply one edge worth of inputs and queue what the following edge must produce.
  task automatic step(input bit d16, input logic r, input logic e, input logic u, input logic l,
                      input logic [7:0] lv, input logic [7:0] ecnt, input bit ewrap,
                      input bit ctc, input bit etc_v);
    exp_t x;
    @(posedge clk);
    #2;
    if (d16) begin
      rst_n16 = r; en16 = e; up16 = u; load16 = l; load_val16 = lv[3:0];
    end else begin
      rst_n = r; en = e; up = u; load = l; load_val = lv;
    end
    x.d16 = d16; x.id = vec_id; x.chk_tc = ctc; x.tc = etc_v; x.cnt = ecnt; x.wrap = ewrap;
    q.push_back(x);
    vec_id++;
  endtask

  initial begin
    // Reset, with EN and LOAD asserted to confirm reset dominates
    step(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    step(0, 0, 1, 1, 1, 8'h45, 8'h00, 0, 1, 0);

    // 1. count up 99 edges, TC low throughout, then wrap on the 100th
    for (int i = 1; i <= 99; i++)
      step(0, 1, 1, 1, 0, 8'h00, {4'(i / 10), 4'(i % 10)}, 0, 1, 0);
    step(0, 1, 1, 1, 0, 8'h00, 8'h00, 1, 1, 1);
    step(0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0);

    // 2. from reset, count down: borrow through all digits
    step(0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 1, 1, 0, 0, 8'h00, 8'h99, 1, 1, 1);
    step(0, 1, 1, 0, 0, 8'h00, 8'h98, 0, 1, 0);

    // 3. carry and borrow across the digit boundary
    step(0, 1, 0, 1, 1, 8'h39, 8'h39, 0, 1, 0);
    step(0, 1, 1, 1, 0, 8'h00, 8'h40, 0, 1, 0);
    step(0, 1, 1, 0, 0, 8'h00, 8'h39, 0, 1, 0);

    // 4. clamped loads; load beats enable and suppresses TC even at 99
    step(0, 1, 0, 1, 1, 8'hAF, 8'h99, 0, 1, 0);
    step(0, 1, 1, 1, 1, 8'h12, 8'h12, 0, 1, 0);
    step(0, 1, 0, 1, 1, 8'h5C, 8'h59, 0, 1, 0);
    step(0, 1, 0, 1, 1, 8'hC3, 8'h93, 0, 1, 0);

    // 5. reset mid-count at 57; reset at 99 while counting up keeps TC low, no wrap
    step(0, 1, 0, 1, 1, 8'h56, 8'h56, 0, 1, 0);
    step(0, 1, 1, 1, 0, 8'h00, 8'h57, 0, 1, 0);
    step(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    step(0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    step(0, 1, 0, 1, 1, 8'h99, 8'h99, 0, 1, 0);
    step(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    step(0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0);

    // 6. single hex digit: 16 steps wrap, F loads unclamped, then down-wrap
    step(1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    for (int i = 1; i <= 15; i++)
      step(1, 1, 1, 1, 0, 8'h00, 8'(i), 0, 1, 0);
    step(1, 1, 1, 1, 0, 8'h00, 8'h00, 1, 1, 1);
    step(1, 1, 1, 0, 0, 8'h00, 8'h0F, 1, 1, 1);
    step(1, 1, 0, 1, 1, 8'h0F, 8'h0F, 0, 1, 0);
    step(1, 1, 1, 0, 0, 8'h00, 8'h0E, 0, 1, 0);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (q.size() > 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    #3;
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
